fcvt_sw_arbiter: RTL

- Shares one combinational integer-to-single-float converter between NREQ requesters; the expected requesters are the pipeline FCVT.S.W path and the multi-cycle/debug port.
- Round-robin arbitration, operand registering, result capture and a valid/ready response channel toward writeback.
- Patches the converter's INT_MIN case (0x80000000) and keeps a conversion counter for performance monitoring.

---
 rtl/fcvt_sw_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fcvt_sw_arbiter.sv
// fcvt_sw_arbiter
// Shares one external combinational int32 -> IEEE-754 single converter between
// NREQ requesters (typically the pipeline FCVT.S.W path and a multi-cycle/debug
// port). A round-robin arbiter picks a requester and registers its operand into
// cvt_a. One cycle later the converter output is captured into rsp_data, which is
// presented on a valid/ready channel toward writeback.
//
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_data             packed int32 operands, requester i at [32i+31:32i]
//   req_tag              packed opaque tags, requester i at [TAGW*i +: TAGW]
//   cvt_a / cvt_b        operand to / result from the external converter
//   rsp_valid/rsp_ready  response handshake
//   rsp_data/id/tag      converted value, owning requester index, its tag
//   busy                 high whenever a conversion or response is outstanding
//   cvt_count            completed responses, wraps modulo 2^16
module fcvt_sw_arbiter #(
  parameter int NREQ = 2,
  parameter int TAGW = 5,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_data,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [31:0]          cvt_a,
  input  logic [31:0]          cvt_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 busy,
  output logic [15:0]          cvt_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  last_grant_reg;
  logic [IDW-1:0]  pend_id_reg;
  logic [TAGW-1:0] pend_tag_reg;
  logic [31:0]     cvt_a_reg;
  logic            rsp_valid_reg;
  logic [31:0]     rsp_data_reg;
  logic [IDW-1:0]  rsp_id_reg;
  logic [TAGW-1:0] rsp_tag_reg;
  logic [15:0]     count_reg;

  logic [31:0]     data_arr [NREQ];
  logic [TAGW-1:0] tag_arr  [NREQ];

  logic [NREQ-1:0] rot_valid;
  logic            found;
  logic            accept;
  logic [IDW-1:0]  winner;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*32 +: 32];
      assign tag_arr[gi]  = req_tag[gi*TAGW +: TAGW];
    end
  endgenerate

  // Round-robin pick: rotate the valid vector so that bit 0 is the requester
  // right after the last grant, then take the lowest set bit.
  always_comb begin
    int off;
    int win_int;
    off       = 0;
    found     = 1'b0;
    rot_valid = NREQ'({req_valid, req_valid} >> (int'(last_grant_reg) + 1));
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    win_int = (int'(last_grant_reg) + 1 + off) % NREQ;
    winner  = IDW'(win_int);
  end

  // Next-state and handshake outputs. A new request may be taken in IDLE, or in
  // RESP in the same cycle the pending response is consumed.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (found) begin
            accept     = 1'b1;
            state_next = CONV;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (accept) begin
      req_ready = NREQ'(1) << winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= IDW'(NREQ - 1);
      pend_id_reg    <= '0;
      pend_tag_reg   <= '0;
      cvt_a_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= '0;
      rsp_tag_reg    <= '0;
      count_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg <= winner;
        cvt_a_reg      <= data_arr[winner];
        pend_id_reg    <= winner;
        pend_tag_reg   <= tag_arr[winner];
      end
      if (state_reg == CONV) begin
        // The converter cannot represent |INT_MIN| in its magnitude path, so
        // that single operand is answered here with -2^31 exactly.
        rsp_data_reg  <= (cvt_a_reg == 32'h8000_0000) ? 32'hCF00_0000 : cvt_b;
        rsp_id_reg    <= pend_id_reg;
        rsp_tag_reg   <= pend_tag_reg;
        rsp_valid_reg <= 1'b1;
      end else if (state_reg == RESP && rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
      if (rsp_valid_reg && rsp_ready) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign cvt_a     = cvt_a_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_tag   = rsp_tag_reg;
  assign busy      = (state_reg != IDLE);
  assign cvt_count = count_reg;

endmodule
